core_bpu_update_sched: RTL and testbench

- Sits after the two branch-resolution units in EX. Each unit produces one bpu_correct_t per cycle.
- Picks the oldest mispredict and issues a single registered front-end redirect/flush.
- Squashes wrong-path results and queues every surviving resolution into a FIFO.
- The FIFO drains one entry per cycle into the BPU training port under a valid/ready handshake, so redirect and training are decoupled.

---
 rtl/core_bpu_update_sched_if.sv | 38 +++
 rtl/core_bpu_update_sched.sv | 114 +++++++++++
 tb/tb_core_bpu_update_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_bpu_update_sched_if.sv
// Resolution record type and the bundled EX-side / BPU-side bus for core_bpu_update_sched.
package core_bpu_pkg;
  typedef struct packed {
    logic        miss;
    logic [31:0] pc;
    logic        true_taken;
    logic [31:0] true_target;
    logic [7:0]  lphr;
    logic [15:0] history;
    logic [1:0]  br_type;
    logic [2:0]  ras_ptr;
  } bpu_correct_t;
endpackage

interface core_bpu_update_sched_if;
  import core_bpu_pkg::*;

  logic         valid0_i;
  bpu_correct_t correct0_i;
  logic         valid1_i;
  bpu_correct_t correct1_i;
  logic         stall_o;
  logic         redirect_o;
  logic [31:0]  redirect_pc_o;
  logic         upd_valid_o;
  bpu_correct_t upd_o;
  logic         upd_ready_i;

  modport master (
    output valid0_i, correct0_i, valid1_i, correct1_i, upd_ready_i,
    input  stall_o, redirect_o, redirect_pc_o, upd_valid_o, upd_o
  );

  modport slave (
    input  valid0_i, correct0_i, valid1_i, correct1_i, upd_ready_i,
    output stall_o, redirect_o, redirect_pc_o, upd_valid_o, upd_o
  );
endinterface

// File: rtl/core_bpu_update_sched.sv
// Oldest-mispredict redirect plus in-order training FIFO for the BPU.
// Optional perf counters enabled by defining BPU_UPDATE_PERF_EN.
module core_bpu_update_sched
  import core_bpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  core_bpu_update_sched_if.slave  bus,
  output logic [31:0]             perf_br_cnt_o,
  output logic [31:0]             perf_miss_cnt_o
);

  typedef enum logic {S_IDLE, S_REDIRECT} state_t;

  localparam logic [PTR_W:0] STALL_LVL = (PTR_W+1)'(DEPTH - 2);

  state_t             state_q, state_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   wr1_addr;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  bpu_correct_t       mem_q [DEPTH];
  bpu_correct_t       win;

  logic       stall, accept, push0, push1, miss0, miss1, miss_any, pop;
  logic [1:0] push_n;

  // Stall looks at registered occupancy only, leaving room for a full pair.
  assign stall  = count_q > STALL_LVL;
  assign accept = !stall && (state_q == S_IDLE);

  // A pipe 0 miss makes the younger slot wrong-path.
  assign push0    = accept && bus.valid0_i;
  assign miss0    = push0 && bus.correct0_i.miss;
  assign push1    = accept && bus.valid1_i && !miss0;
  assign miss1    = push1 && bus.correct1_i.miss;
  assign miss_any = miss0 || miss1;
  assign win      = miss0 ? bus.correct0_i : bus.correct1_i;
  assign push_n   = {1'b0, push0} + {1'b0, push1};
  assign pop      = (count_q != '0) && bus.upd_ready_i;
  assign wr1_addr = push0 ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

  always_comb begin
    count_d       = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop);
    wr_ptr_d      = wr_ptr_q + PTR_W'(push_n);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    redirect_pc_d = redirect_pc_q;
    if (miss_any)
      redirect_pc_d = win.true_taken ? win.true_target : win.pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_ptr_q] <= bus.correct0_i;
    if (push1) mem_q[wr1_addr] <= bus.correct1_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (miss_any) state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.redirect_o    = (state_q == S_REDIRECT);
    bus.redirect_pc_o = redirect_pc_q;
    bus.stall_o       = stall;
    bus.upd_valid_o   = (count_q != '0);
    bus.upd_o         = mem_q[rd_ptr_q];
  end

`ifdef BPU_UPDATE_PERF_EN
  logic [31:0] perf_br_q, perf_miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q   <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_br_q   <= perf_br_q + 32'(push_n);
      perf_miss_q <= perf_miss_q + 32'(miss_any);
    end
  end

  assign perf_br_cnt_o   = perf_br_q;
  assign perf_miss_cnt_o = perf_miss_q;
`else
  assign perf_br_cnt_o   = '0;
  assign perf_miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_core_bpu_update_sched.sv
// Directed bench for core_bpu_update_sched: redirect, squash, backpressure, wrap, reset, perf.
module tb_core_bpu_update_sched;
  import core_bpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] perf_br, perf_miss;
  int checks = 0;
  int errors = 0;
  int exp_br, exp_miss;

  always #5 clk = ~clk;

  core_bpu_update_sched_if bus ();

  core_bpu_update_sched #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .perf_br_cnt_o   (perf_br),
    .perf_miss_cnt_o (perf_miss)
  );

  function automatic bpu_correct_t mk(input logic miss, input logic [31:0] pc,
                                      input logic taken, input logic [31:0] tgt);
    bpu_correct_t e;
    e.miss        = miss;
    e.pc          = pc;
    e.true_taken  = taken;
    e.true_target = tgt;
    e.lphr        = pc[9:2];
    e.history     = pc[17:2] ^ 16'hA5A5;
    e.br_type     = 2'b01;
    e.ras_ptr     = 3'd2;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input bpu_correct_t obs, input bpu_correct_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed pc %0h miss %0b expected pc %0h miss %0b",
             tag, obs.pc, obs.miss, exp.pc, exp.miss);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input bpu_correct_t c0, input logic v1, input bpu_correct_t c1);
    bus.valid0_i   = v0;
    bus.correct0_i = c0;
    bus.valid1_i   = v1;
    bus.correct1_i = c1;
  endtask

  bpu_correct_t e0, e1, ea, eb, ec, ed, ee, ef, eg, eh, ei, ej, ek, nul;

  initial begin
`ifdef BPU_UPDATE_PERF_EN
    exp_br = 5; exp_miss = 2;
`else
    exp_br = 0; exp_miss = 0;
`endif
    nul = '0;
    rst = 1'b1;
    drive(1'b0, nul, 1'b0, nul);
    bus.upd_ready_i = 1'b0;
    cyc(); cyc();
    chk("rst_redirect", 32'(bus.redirect_o), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc_o, 32'd0);
    chk("rst_upd_valid", 32'(bus.upd_valid_o), 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_count", 32'(dut.count_q), 32'd0);
    chk("rst_perf_br", perf_br, 32'd0);
    chk("rst_perf_miss", perf_miss, 32'd0);
    rst = 1'b0;

    // Pipe 0 taken miss squashes pipe 1
    e0 = mk(1'b1, 32'h1C000040, 1'b1, 32'h1C000100);
    e1 = mk(1'b0, 32'h1C000044, 1'b0, 32'h0);
    drive(1'b1, e0, 1'b1, e1);
    cyc();
    chk("t1_redirect", 32'(bus.redirect_o), 32'd1);
    chk("t1_redirect_pc", bus.redirect_pc_o, 32'h1C000100);
    chk("t1_count", 32'(dut.count_q), 32'd1);
    chk_e("t1_head", bus.upd_o, e0);
    drive(1'b1, mk(1'b1, 32'h1C000200, 1'b1, 32'h0), 1'b1, mk(1'b0, 32'h1C000204, 1'b0, 32'h0));
    cyc();
    chk("t1_redirect_end", 32'(bus.redirect_o), 32'd0);
    chk("t1_drop_count", 32'(dut.count_q), 32'd1);
    chk("t1_pc_hold", bus.redirect_pc_o, 32'h1C000100);
    drive(1'b0, nul, 1'b0, nul);
    bus.upd_ready_i = 1'b1;
    cyc();
    chk("t1_drained", 32'(bus.upd_valid_o), 32'd0);
    bus.upd_ready_i = 1'b0;

    // Pipe 1 not-taken miss at top of address space
    e0 = mk(1'b0, 32'h00000100, 1'b1, 32'h00000200);
    e1 = mk(1'b1, 32'hFFFFFFFC, 1'b0, 32'h00000040);
    drive(1'b1, e0, 1'b1, e1);
    cyc();
    chk("t2_redirect", 32'(bus.redirect_o), 32'd1);
    chk("t2_redirect_pc_wrap", bus.redirect_pc_o, 32'h0);
    chk("t2_count", 32'(dut.count_q), 32'd2);
    chk_e("t2_head0", bus.upd_o, e0);
    drive(1'b0, nul, 1'b0, nul);
    bus.upd_ready_i = 1'b1;
    cyc();
    chk_e("t2_head1", bus.upd_o, e1);
    chk("t2_count1", 32'(dut.count_q), 32'd1);
    cyc();
    chk("t2_count0", 32'(dut.count_q), 32'd0);
    bus.upd_ready_i = 1'b0;

    // Backpressure
    ea = mk(1'b0, 32'h2000, 1'b1, 32'h2100);
    eb = mk(1'b0, 32'h2004, 1'b0, 32'h0);
    ec = mk(1'b0, 32'h2008, 1'b1, 32'h2200);
    ed = mk(1'b0, 32'h200C, 1'b0, 32'h0);
    ee = mk(1'b0, 32'h2010, 1'b0, 32'h0);
    ef = mk(1'b0, 32'h2014, 1'b0, 32'h0);
    drive(1'b1, ea, 1'b1, eb);
    cyc();
    chk("t3_count2", 32'(dut.count_q), 32'd2);
    chk("t3_stall_at2", 32'(bus.stall_o), 32'd0);
    drive(1'b1, ec, 1'b1, ed);
    cyc();
    chk("t3_count4", 32'(dut.count_q), 32'd4);
    chk("t3_stall_at4", 32'(bus.stall_o), 32'd1);
    drive(1'b1, ee, 1'b1, ef);
    cyc();
    chk("t3_ignored_count", 32'(dut.count_q), 32'd4);
    chk_e("t3_headA", bus.upd_o, ea);
    drive(1'b0, nul, 1'b0, nul);
    bus.upd_ready_i = 1'b1;
    cyc();
    chk_e("t3_headB", bus.upd_o, eb);
    chk("t3_stall_at3", 32'(bus.stall_o), 32'd1);
    cyc();
    chk_e("t3_headC", bus.upd_o, ec);
    chk("t3_stall_at2b", 32'(bus.stall_o), 32'd0);
    cyc();
    chk_e("t3_headD", bus.upd_o, ed);
    cyc();
    chk("t3_empty", 32'(bus.upd_valid_o), 32'd0);
    bus.upd_ready_i = 1'b0;

    // Push 2 / pop 1 with write pointer wrapping 2 -> 0
    eg = mk(1'b0, 32'h3000, 1'b0, 32'h0);
    drive(1'b1, eg, 1'b0, nul);
    cyc();
    chk("t4_wr_ptr0", 32'(dut.wr_ptr_q), 32'd0);
    drive(1'b0, nul, 1'b0, nul);
    bus.upd_ready_i = 1'b1;
    cyc();
    bus.upd_ready_i = 1'b0;
    eh = mk(1'b0, 32'h3010, 1'b1, 32'h3100);
    ei = mk(1'b0, 32'h3014, 1'b0, 32'h0);
    ej = mk(1'b0, 32'h3018, 1'b1, 32'h3200);
    ek = mk(1'b0, 32'h301C, 1'b0, 32'h0);
    drive(1'b1, eh, 1'b1, ei);
    cyc();
    chk("t4_count2", 32'(dut.count_q), 32'd2);
    chk("t4_wr_ptr2", 32'(dut.wr_ptr_q), 32'd2);
    drive(1'b1, ej, 1'b1, ek);
    bus.upd_ready_i = 1'b1;
    cyc();
    chk("t4_count3", 32'(dut.count_q), 32'd3);
    chk("t4_wr_wrap", 32'(dut.wr_ptr_q), 32'd0);
    chk_e("t4_headI", bus.upd_o, ei);
    drive(1'b0, nul, 1'b0, nul);
    cyc();
    chk_e("t4_headJ", bus.upd_o, ej);
    cyc();
    chk_e("t4_headK", bus.upd_o, ek);
    chk("t4_count1", 32'(dut.count_q), 32'd1);
    bus.upd_ready_i = 1'b0;

    // Reset with count 3 and a redirect pending
    drive(1'b1, mk(1'b0, 32'h3020, 1'b0, 32'h0), 1'b1, mk(1'b1, 32'h3024, 1'b1, 32'h4000));
    cyc();
    chk("t5_count3", 32'(dut.count_q), 32'd3);
    chk("t5_redirect", 32'(bus.redirect_o), 32'd1);
    chk("t5_redirect_pc", bus.redirect_pc_o, 32'h4000);
    rst = 1'b1;
    drive(1'b0, nul, 1'b0, nul);
    cyc();
    rst = 1'b0;
    chk("t5_rst_count", 32'(dut.count_q), 32'd0);
    chk("t5_rst_upd_valid", 32'(bus.upd_valid_o), 32'd0);
    chk("t5_rst_redirect", 32'(bus.redirect_o), 32'd0);
    chk("t5_rst_state", 32'(dut.state_q), 32'd0);

    // Perf: 5 accepted branches, 2 misses, one wrong-path pair dropped
    bus.upd_ready_i = 1'b1;
    drive(1'b1, mk(1'b0, 32'h5000, 1'b1, 32'h5100), 1'b1, mk(1'b0, 32'h5004, 1'b0, 32'h0));
    cyc();
    drive(1'b1, mk(1'b1, 32'h5008, 1'b1, 32'h7000), 1'b1, mk(1'b0, 32'h500C, 1'b0, 32'h0));
    cyc();
    chk("t6_redirect_pc_a", bus.redirect_pc_o, 32'h7000);
    drive(1'b1, mk(1'b1, 32'h5010, 1'b1, 32'h0), 1'b1, mk(1'b1, 32'h5014, 1'b1, 32'h0));
    cyc();
    drive(1'b1, mk(1'b0, 32'h6000, 1'b1, 32'h6100), 1'b1, mk(1'b1, 32'h6004, 1'b0, 32'h0));
    cyc();
    chk("t6_redirect_b", 32'(bus.redirect_o), 32'd1);
    chk("t6_redirect_pc_b", bus.redirect_pc_o, 32'h6008);
    drive(1'b0, nul, 1'b0, nul);
    cyc();
    chk("t6_perf_br", perf_br, 32'(exp_br));
    chk("t6_perf_miss", perf_miss, 32'(exp_miss));
    cyc(); cyc(); cyc();
    chk("t6_drained", 32'(bus.upd_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
